bcd_scan_counter: RTL and testbench

Multi-digit BCD up/down event counter with a time-multiplexed digit scanner. It sits directly upstream of the seven-segment `Encoder`. Its `data` output feeds the encoder's 4-bit `data` input one digit at a time, and `digit_sel` enables the matching physical display position. It turns pulse events into a scanned decimal readout.

---
 rtl/bcd_scan_counter.sv | 123 ++++++++++++
 tb/tb_bcd_scan_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down event counter with a time-multiplexed digit scanner for a 7-segment encoder.
// Optional leading-zero blanking on the data output: define BCD_SCAN_BLANK_LZ_EN.
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [3:0]            data,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  wrap_up,
    output logic                  wrap_dn
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_count;
    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [DIGITS:0]     w_cy;
    logic [DIGITS:0]     w_bw;
    logic [3:0]          w_d;
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic                r_wrap_up;
    logic                r_wrap_dn;
    logic [3:0]          w_data;

    // Ripple carry/borrow per digit; the final carry/borrow flags the all-9s/all-0s wrap.
    always_comb begin
        w_inc   = r_count;
        w_dec   = r_count;
        w_cy    = '0;
        w_bw    = '0;
        w_d     = 4'd0;
        w_cy[0] = 1'b1;
        w_bw[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_d = r_count[4*i +: 4];
            if (w_cy[i])
                w_inc[4*i +: 4] = (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
            if (w_bw[i])
                w_dec[4*i +: 4] = (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;
            w_cy[i+1] = w_cy[i] && (w_d == 4'd9);
            w_bw[i+1] = w_bw[i] && (w_d == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
        end else begin
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
            if (clear) begin
                r_count <= '0;
            end else if (inc && !dec) begin
                r_count   <= w_inc;
                r_wrap_up <= w_cy[DIGITS];
            end else if (dec && !inc) begin
                r_count   <= w_dec;
                r_wrap_dn <= w_bw[DIGITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

`ifdef BCD_SCAN_BLANK_LZ_EN
    logic [DIGITS:0] w_hz;

    // w_hz[i]: digit i and every digit above it are zero.
    always_comb begin
        w_hz         = '0;
        w_hz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--)
            w_hz[i] = w_hz[i+1] && (r_count[4*i +: 4] == 4'd0);
    end

    always_comb begin
        w_data = 4'd0;
        for (int i = 0; i < DIGITS; i++)
            if (r_idx == IW'(i))
                w_data = (i > 0 && w_hz[i]) ? 4'hF : r_count[4*i +: 4];
    end
`else
    always_comb begin
        w_data = 4'd0;
        for (int i = 0; i < DIGITS; i++)
            if (r_idx == IW'(i))
                w_data = r_count[4*i +: 4];
    end
`endif

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < DIGITS; i++)
            digit_sel[i] = (r_idx == IW'(i));
    end

    assign count_bcd = r_count;
    assign data      = w_data;
    assign wrap_up   = r_wrap_up;
    assign wrap_dn   = r_wrap_dn;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4): stimulus queues expectations, a monitor compares at negedge.
module tb_bcd_scan_counter;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, inc, dec;
    logic [15:0] count_bcd;
    logic [3:0]  data;
    logic [3:0]  digit_sel;
    logic        wrap_up, wrap_dn;

    bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inc(inc), .dec(dec),
        .count_bcd(count_bcd), .data(data), .digit_sel(digit_sel),
        .wrap_up(wrap_up), .wrap_dn(wrap_dn)
    );

    always #5 clk = ~clk;

    typedef enum int {K_COUNT, K_DATA, K_SEL, K_WUP, K_WDN} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference time base: rising edges seen since reset release.
    int tb_cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;

    function automatic logic [31:0] actual(kind_e k);
        case (k)
            K_COUNT: return {16'h0, count_bcd};
            K_DATA:  return {28'h0, data};
            K_SEL:   return {28'h0, digit_sel};
            K_WUP:   return {31'h0, wrap_up};
            default: return {31'h0, wrap_dn};
        endcase
    endfunction

    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.kind);
                n_cmp++;
                if (a !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0h expected %0h (t=%0t)", e.name, a, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_v(string n, kind_e k, logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = k; e.exp = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit i, bit d, bit c, int n);
        inc = i; dec = d; clear = c;
        repeat (n) tick();
        inc = 1'b0; dec = 1'b0; clear = 1'b0;
    endtask

    task automatic no_wrap(string n);
        expect_v({n, "_wup"}, K_WUP, 0);
        expect_v({n, "_wdn"}, K_WDN, 0);
    endtask

    task automatic align_frame();
        int guard = 0;
        while ((tb_cyc % (DIGITS * SCAN_DIV)) != 0 && guard < 2 * DIGITS * SCAN_DIV) begin
            tick();
            guard++;
        end
    endtask

    task automatic check_frame(string n, logic [3:0] d0, logic [3:0] d1, logic [3:0] d2, logic [3:0] d3);
        logic [3:0] tbl [4];
        tbl[0] = d0; tbl[1] = d1; tbl[2] = d2; tbl[3] = d3;
        align_frame();
        for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
            expect_v({n, "_sel"},  K_SEL,  32'(4'b0001 << (k / SCAN_DIV)));
            expect_v({n, "_data"}, K_DATA, 32'(tbl[k / SCAN_DIV]));
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; inc = 1'b0; dec = 1'b0;
        #12;
        expect_v("rst_count", K_COUNT, 0);
        expect_v("rst_sel",   K_SEL,   1);
        expect_v("rst_data",  K_DATA,  0);
        no_wrap("rst");
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();

        // 12 increments, never a wrap
        inc = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            no_wrap("inc12");
        end
        inc = 1'b0;
        expect_v("inc12_count", K_COUNT, 32'h0012);

        // Preload 9999 then roll over
        drive(0, 0, 1, 1);
        expect_v("clr_count", K_COUNT, 0);
        drive(1, 0, 0, 9999);
        expect_v("pre9999_count", K_COUNT, 32'h9999);
        no_wrap("pre9999");
        drive(1, 0, 0, 1);
        expect_v("wrapup_count", K_COUNT, 0);
        expect_v("wrapup_pulse", K_WUP, 1);
        expect_v("wrapup_wdn",   K_WDN, 0);
        tick();
        expect_v("wrapup_after", K_WUP, 0);
        expect_v("wrapup_hold",  K_COUNT, 0);

        // Underflow from 0, then inc+dec together holds
        drive(0, 1, 0, 1);
        expect_v("wrapdn_count", K_COUNT, 32'h9999);
        expect_v("wrapdn_pulse", K_WDN, 1);
        expect_v("wrapdn_wup",   K_WUP, 0);
        tick();
        expect_v("wrapdn_after", K_WDN, 0);
        inc = 1'b1; dec = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_v("both_count", K_COUNT, 32'h9999);
            no_wrap("both");
        end
        inc = 1'b0; dec = 1'b0;

        // Clear beats increment at 0305 and decrement at 0
        drive(0, 0, 1, 1);
        drive(1, 0, 0, 305);
        expect_v("c305_count", K_COUNT, 32'h0305);
        drive(1, 0, 1, 1);
        expect_v("clrinc_count", K_COUNT, 0);
        no_wrap("clrinc");
        drive(0, 1, 1, 1);
        expect_v("clrdec_count", K_COUNT, 0);
        no_wrap("clrdec");

        // Mid-value borrow: 0100 - 1 = 0099
        drive(1, 0, 0, 100);
        drive(0, 1, 0, 1);
        expect_v("borrow_count", K_COUNT, 32'h0099);

        // Scan of 1234
        drive(0, 0, 1, 1);
        drive(1, 0, 0, 1234);
        expect_v("c1234_count", K_COUNT, 32'h1234);
        check_frame("scan1234", 4'h4, 4'h3, 4'h2, 4'h1);

        // Scan of 0040, blanked or raw
        drive(0, 0, 1, 1);
        drive(1, 0, 0, 40);
        expect_v("c0040_count", K_COUNT, 32'h0040);
`ifdef BCD_SCAN_BLANK_LZ_EN
        check_frame("scan0040", 4'h0, 4'h4, 4'hF, 4'hF);
`else
        check_frame("scan0040", 4'h0, 4'h4, 4'h0, 4'h0);
`endif

        // Asynchronous reset mid-frame (digit 1 selected, showing 4)
        align_frame();
        repeat (SCAN_DIV + 2) tick();
        expect_v("pre_rst_sel",  K_SEL,  32'b0010);
        expect_v("pre_rst_data", K_DATA, 4);
        tick();
        #1 rst_n = 1'b0;
        expect_v("arst_sel",   K_SEL,   1);
        expect_v("arst_data",  K_DATA,  0);
        expect_v("arst_count", K_COUNT, 0);
        no_wrap("arst");
        tick();
        #3 rst_n = 1'b1;
        tick();
        expect_v("post_rst_sel", K_SEL, 1);
        drive(1, 0, 0, 1);
        expect_v("post_rst_count", K_COUNT, 1);

        begin
            int guard = 0;
            while (q.size() > 0 && guard < 10) begin
                tick();
                guard++;
            end
            if (q.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d pending expected 0", q.size());
            end
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
